// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: lane alignment, load extraction and the M->W register.
// Optional misalignment trapping is enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NBYTE = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteEnM,
    input  logic              MemtoRegM,
    input  logic              JALM,
    input  logic              MemReadEnM,
    input  logic              MemWriteEnM,
    input  logic [1:0]        MemSizeM,
    input  logic              LoadUnsignedM,
    input  logic [4:0]        RdM,
    input  logic [XLEN-1:0]   PcPlus4M,
    input  logic [XLEN-1:0]   StoreDataM,
    input  logic [XLEN-1:0]   ALUResultM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [NBYTE-1:0]  dmem_be,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ack,
    output logic              StallM,
    output logic              RegWriteEnW,
    output logic              MemtoRegW,
    output logic              JALW,
    output logic [4:0]        RdW,
    output logic [XLEN-1:0]   PcPlus4W,
    output logic [XLEN-1:0]   ALUResultW,
    output logic [XLEN-1:0]   ReadDataW,
    output logic              MisalignW
);

    localparam int unsigned OFFW = $clog2(NBYTE);
    localparam int unsigned SHW  = OFFW + 3;

    typedef enum logic {IDLE, WAIT} stateT;
    stateT state;

    logic [OFFW-1:0]  offset;
    logic [SHW-1:0]   shamt;
    logic [1:0]       sizeEff;
    logic [NBYTE-1:0] sizeMask;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  loadData;
    logic             access;
    logic             misalign;
    logic             readDone;

    assign offset  = ALUResultM[OFFW-1:0];
    assign shamt   = {offset, 3'b000};
    // A 32-bit datapath has no doubleword, so size 11 degrades to a word access.
    assign sizeEff = (XLEN == 32 && MemSizeM == 2'b11) ? 2'b10 : MemSizeM;
    assign access  = MemReadEnM | MemWriteEnM;

`ifdef MEM_MISALIGN_CHECK_EN
    logic [3:0]      sizeBytes;
    logic [OFFW-1:0] alignMask;
    assign sizeBytes = 4'd1 << sizeEff;
    assign alignMask = OFFW'(sizeBytes - 4'd1);
    assign misalign  = access & (|(offset & alignMask));
`else
    assign misalign  = 1'b0;
`endif

    always_comb begin
        sizeMask = NBYTE'(1);
        case (sizeEff)
            2'b00:   sizeMask = NBYTE'(8'h01);
            2'b01:   sizeMask = NBYTE'(8'h03);
            2'b10:   sizeMask = NBYTE'(8'h0F);
            default: sizeMask = NBYTE'(8'hFF);
        endcase
    end

    // Request side is purely combinational; upstream holds M inputs stable while stalled.
    assign dmem_req   = rst & access & ~misalign;
    assign dmem_we    = dmem_req & MemWriteEnM;
    assign dmem_addr  = {ALUResultM[XLEN-1:OFFW], OFFW'(0)};
    assign dmem_be    = dmem_req ? (sizeMask << offset) : '0;
    assign dmem_wdata = StoreDataM << shamt;
    assign StallM     = dmem_req & ~dmem_ack;
    assign readDone   = dmem_req & dmem_ack & ~MemWriteEnM;

    assign shifted = dmem_rdata >> shamt;

    always_comb begin
        loadData = shifted;
        if (LoadUnsignedM) begin
            case (sizeEff)
                2'b00:   loadData = XLEN'(shifted[7:0]);
                2'b01:   loadData = XLEN'(shifted[15:0]);
                2'b10:   loadData = XLEN'(shifted[31:0]);
                default: loadData = shifted;
            endcase
        end else begin
            case (sizeEff)
                2'b00:   loadData = XLEN'($signed(shifted[7:0]));
                2'b01:   loadData = XLEN'($signed(shifted[15:0]));
                2'b10:   loadData = XLEN'($signed(shifted[31:0]));
                default: loadData = shifted;
            endcase
        end
    end

    // Tracks whether an issued access is still waiting for its ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (StallM) state <= WAIT;
                WAIT:    if (dmem_ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // M->W register: bubbles the control bits while stalled, holds the data fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteEnW <= 1'b0;
            MemtoRegW   <= 1'b0;
            JALW        <= 1'b0;
            RdW         <= '0;
            PcPlus4W    <= '0;
            ALUResultW  <= '0;
            ReadDataW   <= '0;
            MisalignW   <= 1'b0;
        end else if (StallM) begin
            RegWriteEnW <= 1'b0;
            MemtoRegW   <= 1'b0;
            JALW        <= 1'b0;
        end else begin
            RegWriteEnW <= RegWriteEnM & ~misalign;
            MemtoRegW   <= MemtoRegM;
            JALW        <= JALM;
            RdW         <= RdM;
            PcPlus4W    <= PcPlus4M;
            ALUResultW  <= ALUResultM;
            ReadDataW   <= readDone ? loadData : '0;
            MisalignW   <= misalign;
        end
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter XLEN, default 64, SHALL set the datapath width; legal values are 32 and 64.
REQ-002 Parameter NBYTE, default XLEN/8, SHALL set the byte-lane count; it is derived from XLEN and not overridden.
REQ-003 Ports SHALL be:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM  in  1 each  M-stage controls.
- MemSizeM  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
- LoadUnsignedM  in  1  zero-extend the load result.
- RdM  in  5  destination register.
- PcPlus4M, StoreDataM, ALUResultM  in  XLEN each  PC+4, store data, effective address.
- dmem_req, dmem_we  out  1 each  memory request, write enable.
- dmem_addr, dmem_wdata  out  XLEN each  aligned address, lane-positioned write data.
- dmem_be  out  NBYTE  byte enables.
- dmem_rdata  in  XLEN  read data, valid with dmem_ack.
- dmem_ack  in  1  access complete.
- StallM  out  1  hold the M stage and all upstream stages.
- RegWriteEnW, MemtoRegW, JALW  out  1 each  registered W-stage controls.
- RdW  out  5  registered destination register.
- PcPlus4W, ALUResultW, ReadDataW  out  XLEN each  registered W-stage data.
- MisalignW  out  1  registered misalignment flag.

Function
REQ-004 The FSM SHALL have two states, IDLE and WAIT.
REQ-005 An access is MemReadEnM|MemWriteEnM; with both set, the write SHALL take priority.
REQ-006 IDLE with an access: dmem_req=1 combinationally; ack in the same cycle completes with zero wait, otherwise next state is WAIT.
REQ-007 In WAIT, dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be SHALL hold constant until dmem_ack; on ack the FSM returns to IDLE.
REQ-008 StallM = access pending AND NOT dmem_ack, combinational; upstream holds the M inputs stable while StallM=1.
REQ-009 dmem_addr = ALUResultM with the low log2(NBYTE) bits cleared; offset = those low bits.
REQ-010 dmem_be = the size mask (1, 3, 0xF or 0xFF lanes) shifted left by offset.
REQ-011 dmem_wdata = StoreDataM shifted left by 8*offset.
REQ-012 Load data SHALL be formed as: dmem_rdata shifted right by 8*offset, truncated to the access size, then sign-extended to XLEN, or zero-extended when LoadUnsignedM=1.
REQ-013 With XLEN=32, MemSizeM=11 SHALL be treated as word.
REQ-014 The W register SHALL load all fields on a cycle where StallM=0.
REQ-015 On a cycle where StallM=1, the W register SHALL load RegWriteEnW=0, MemtoRegW=0, JALW=0 (bubble) and hold all other fields.
REQ-016 ReadDataW SHALL load the extracted load data on a read completion, otherwise 0.
REQ-017 Latency: a non-memory op, or a zero-wait access, SHALL appear at the W outputs 1 cycle after presentation; an access acked after N wait cycles SHALL appear N+1 cycles after presentation.
REQ-018 dmem_req SHALL be 0 whenever no access is presented, or when the access is suppressed under REQ-023.

Reset
REQ-019 When rst=0, the FSM SHALL go to IDLE immediately (asynchronously), including mid-access from WAIT.
REQ-020 While rst=0: dmem_req=0, StallM=0, and all W outputs and MisalignW are 0.
REQ-021 A dmem_ack arriving during or after reset with no request outstanding SHALL be ignored.

Configuration
REQ-022 Macro MEM_MISALIGN_CHECK_EN SHALL enable misalignment detection.
REQ-023 With MEM_MISALIGN_CHECK_EN defined, an access whose ALUResultM is not a multiple of the access size SHALL:
- issue no dmem_req;
- set StallM=0;
- load MisalignW=1 and RegWriteEnW=0 in the W register, all other fields as for a normal completion.
REQ-024 Without MEM_MISALIGN_CHECK_EN, no misalignment check is performed, MisalignW is constant 0, and lanes beyond the top byte are dropped.

Verification
REQ-025 XLEN=64, signed byte load, addr 0x1003, dmem_rdata=0x00000000_80000000, ack same cycle -> dmem_be=0x08, ReadDataW=0xFFFFFFFF_FFFFFF80 next cycle, StallM never asserted.
REQ-026 Half store at 0x2006, StoreDataM=0xBEEF, ack after 3 cycles -> dmem_be=0xC0, dmem_wdata[63:48]=0xBEEF, StallM high 3 cycles, 3 bubbles at W, then the store reaches W.
REQ-027 Unsigned word load at 0x0004, rdata=0xFFFFFFFF_00000000 -> ReadDataW=0x00000000_FFFFFFFF.
REQ-028 rst driven low while in WAIT -> dmem_req and StallM drop without waiting for a clock; a later ack is ignored; the next op completes normally.
REQ-029 MEM_MISALIGN_CHECK_EN defined, word load at 0x0002 -> no dmem_req, MisalignW=1, RegWriteEnW=0. Without the macro -> request issued with dmem_be=0x3C.
REQ-030 Back-to-back zero-wait loads to x5 then x6 -> RdW=5, then RdW=6 on consecutive cycles, no stall.
